// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the fetch PC and the IF/ID pipeline register.
// Each edge resolves Reset, then branch redirect, then stall, then normal advance.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC    = 32'h00000000,
  parameter logic [31:0] BUBBLE_WORD = 32'h00000000
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic [31:0] IF_instruction,
  output logic [31:0] IF_pc,
  output logic [31:0] ID_instruction,
  output logic [31:0] ID_pc,
  output logic [31:0] ID_pc_plus4,
  output logic        ID_valid,
  output logic [15:0] fetch_count
);

  localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

  logic [31:0] r_pc;
  logic [31:0] r_id_instruction;
  logic [31:0] r_id_pc;
  logic [31:0] r_id_pc_plus4;
  logic        r_id_valid;
  logic [15:0] r_fetch_count;

  logic [31:0] w_pc_plus4;
  logic [31:0] w_branch_pc;
  logic        w_unused_tgt_bits;

  // Wraps modulo 2^32 with no overflow indication.
  assign w_pc_plus4        = r_pc + 32'd4;
  assign w_branch_pc       = {branch_target[31:2], 2'b00};
  assign w_unused_tgt_bits = ^branch_target[1:0];

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_pc             <= RESET_PC_ALIGNED;
      r_id_instruction <= BUBBLE_WORD;
      r_id_pc          <= 32'd0;
      r_id_pc_plus4    <= 32'd0;
      r_id_valid       <= 1'b0;
      r_fetch_count    <= 16'd0;
    end else if (branch_taken) begin
      // Redirect wins over stall; the wrong-path word in IF is squashed.
      r_pc             <= w_branch_pc;
      r_id_instruction <= BUBBLE_WORD;
      r_id_pc          <= 32'd0;
      r_id_pc_plus4    <= 32'd0;
      r_id_valid       <= 1'b0;
    end else if (!stall) begin
      r_pc             <= w_pc_plus4;
      r_id_instruction <= IF_instruction;
      r_id_pc          <= r_pc;
      r_id_pc_plus4    <= w_pc_plus4;
      r_id_valid       <= 1'b1;
      if (r_fetch_count != 16'hFFFF) begin
        r_fetch_count <= r_fetch_count + 16'd1;
      end
    end
  end

  assign IF_pc          = r_pc;
  assign ID_instruction = r_id_instruction;
  assign ID_pc          = r_id_pc;
  assign ID_pc_plus4    = r_id_pc_plus4;
  assign ID_valid       = r_id_valid;
  assign fetch_count    = r_fetch_count;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: random ROM contents, directed scenarios and random
// control traffic checked against an edge-level behavioural model.
module tb_if_fetch_stage;

  localparam logic [31:0] RESET_PC    = 32'h00000000;
  localparam logic [31:0] BUBBLE_WORD = 32'h00000013;

  logic        Clk;
  logic        Reset;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] IF_instruction;
  logic [31:0] IF_pc;
  logic [31:0] ID_instruction;
  logic [31:0] ID_pc;
  logic [31:0] ID_pc_plus4;
  logic        ID_valid;
  logic [15:0] fetch_count;

  int n_cmp;
  int n_fail;

  logic [31:0] rom [0:63];

  // Reference model state
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic [31:0] m_id_pc;
  logic [31:0] m_p4;
  logic        m_valid;
  logic [15:0] m_cnt;

  if_fetch_stage #(
    .RESET_PC(RESET_PC),
    .BUBBLE_WORD(BUBBLE_WORD)
  ) dut (
    .Clk(Clk),
    .Reset(Reset),
    .stall(stall),
    .branch_taken(branch_taken),
    .branch_target(branch_target),
    .IF_instruction(IF_instruction),
    .IF_pc(IF_pc),
    .ID_instruction(ID_instruction),
    .ID_pc(ID_pc),
    .ID_pc_plus4(ID_pc_plus4),
    .ID_valid(ID_valid),
    .fetch_count(fetch_count)
  );

  // Clock / ROM block
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;
  assign IF_instruction = rom[IF_pc[7:2]];

  function automatic logic [144:0] dut_vec();
    return {IF_pc, ID_instruction, ID_pc, ID_pc_plus4, ID_valid, fetch_count};
  endfunction

  function automatic logic [144:0] mdl_vec();
    return {m_pc, m_instr, m_id_pc, m_p4, m_valid, m_cnt};
  endfunction

  task automatic model_edge(input logic rst, input logic stl, input logic br,
                            input logic [31:0] tgt);
    if (rst) begin
      m_pc = RESET_PC & 32'hFFFFFFFC;
      m_instr = BUBBLE_WORD; m_id_pc = 0; m_p4 = 0; m_valid = 0; m_cnt = 0;
    end else if (br) begin
      m_pc = tgt & 32'hFFFFFFFC;
      m_instr = BUBBLE_WORD; m_id_pc = 0; m_p4 = 0; m_valid = 0;
    end else if (!stl) begin
      m_instr = rom[m_pc[7:2]];
      m_id_pc = m_pc;
      m_p4    = m_pc + 32'd4;
      m_pc    = m_pc + 32'd4;
      m_valid = 1'b1;
      m_cnt   = (m_cnt == 16'hFFFF) ? 16'hFFFF : m_cnt + 16'd1;
    end
  endtask

  // Driver: apply inputs, take one edge, advance model, settle before sampling.
  task automatic step(input logic rst, input logic stl, input logic br,
                      input logic [31:0] tgt);
    Reset = rst; stall = stl; branch_taken = br; branch_target = tgt;
    @(posedge Clk);
    model_edge(rst, stl, br, tgt);
    #1;
  endtask

  task automatic test_reset();
    step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b1, 32'h80);
    n_cmp++;
    if (dut_vec() !== {RESET_PC, BUBBLE_WORD, 32'h0, 32'h0, 1'b0, 16'h0}) begin
      n_fail++;
      $display("FAIL reset_state: got %h exp %h", dut_vec(),
               {RESET_PC, BUBBLE_WORD, 32'h0, 32'h0, 1'b0, 16'h0});
    end
  endtask

  task automatic test_sequential();
    step(1'b1, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 1'b0, 32'h0);
      n_cmp++;
      if (dut_vec() !== mdl_vec()) begin
        n_fail++;
        $display("FAIL seq_%0d: got %h exp %h", i, dut_vec(), mdl_vec());
      end
      n_cmp++;
      if (ID_pc !== 32'(4 * i) || IF_pc !== 32'(4 * i + 4) ||
          ID_instruction !== rom[i] || ID_pc_plus4 !== 32'(4 * i + 4)) begin
        n_fail++;
        $display("FAIL seq_abs_%0d: got pc=%h id_pc=%h instr=%h exp pc=%h id_pc=%h instr=%h",
                 i, IF_pc, ID_pc, ID_instruction, 4 * i + 4, 4 * i, rom[i]);
      end
    end
    n_cmp++;
    if (fetch_count !== 16'd4) begin
      n_fail++;
      $display("FAIL seq_count: got %0d exp 4", fetch_count);
    end
  endtask

  task automatic test_stall();
    step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 1'b0, 32'h0);
      n_cmp++;
      if (dut_vec() !== mdl_vec() || IF_pc !== 32'h8 || ID_pc !== 32'h4) begin
        n_fail++;
        $display("FAIL stall_hold_%0d: got %h exp %h", i, dut_vec(), mdl_vec());
      end
    end
    step(1'b0, 1'b0, 1'b0, 32'h0);
    n_cmp++;
    if (ID_pc !== 32'h8 || IF_pc !== 32'hC || fetch_count !== 16'd3) begin
      n_fail++;
      $display("FAIL stall_release: got id_pc=%h pc=%h cnt=%0d exp 8 c 3",
               ID_pc, IF_pc, fetch_count);
    end
  endtask

  task automatic test_branch();
    step(1'b1, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b1, 32'h00000023);
    n_cmp++;
    if (IF_pc !== 32'h20 || ID_valid !== 1'b0 || ID_instruction !== BUBBLE_WORD ||
        ID_pc !== 32'h0 || ID_pc_plus4 !== 32'h0 || fetch_count !== 16'd3) begin
      n_fail++;
      $display("FAIL branch_flush: got %h exp %h", dut_vec(), mdl_vec());
    end
    step(1'b0, 1'b0, 1'b0, 32'h0);
    n_cmp++;
    if (ID_pc !== 32'h20 || ID_valid !== 1'b1 || ID_instruction !== rom[8] ||
        IF_pc !== 32'h24) begin
      n_fail++;
      $display("FAIL branch_target_fetch: got %h exp %h", dut_vec(), mdl_vec());
    end
  endtask

  task automatic test_branch_stall_reset();
    step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 1'b1, 32'h40);
    n_cmp++;
    if (IF_pc !== 32'h40 || ID_valid !== 1'b0 || ID_instruction !== BUBBLE_WORD) begin
      n_fail++;
      $display("FAIL branch_over_stall: got %h exp %h", dut_vec(), mdl_vec());
    end
    step(1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b1, 32'h40);
    n_cmp++;
    if (IF_pc !== RESET_PC || fetch_count !== 16'd0 || ID_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_over_all: got %h exp %h", dut_vec(), mdl_vec());
    end
    step(1'b0, 1'b0, 1'b0, 32'h0);
    n_cmp++;
    if (ID_instruction !== rom[0] || ID_valid !== 1'b1 || fetch_count !== 16'd1) begin
      n_fail++;
      $display("FAIL first_after_reset: got %h exp %h", dut_vec(), mdl_vec());
    end
  endtask

  task automatic test_wrap();
    step(1'b0, 1'b0, 1'b1, 32'hFFFFFFFF);
    n_cmp++;
    if (IF_pc !== 32'hFFFFFFFC) begin
      n_fail++;
      $display("FAIL wrap_align: got %h exp fffffffc", IF_pc);
    end
    step(1'b0, 1'b0, 1'b0, 32'h0);
    n_cmp++;
    if (IF_pc !== 32'h0 || ID_pc !== 32'hFFFFFFFC || ID_pc_plus4 !== 32'h0 ||
        ID_instruction !== rom[63]) begin
      n_fail++;
      $display("FAIL wrap_advance: got %h exp %h", dut_vec(), mdl_vec());
    end
  endtask

  task automatic test_random();
    logic rst, stl, br;
    logic [31:0] tgt;
    step(1'b1, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 63) == 0);
      stl = ($urandom_range(0, 3) == 0);
      br  = ($urandom_range(0, 7) == 0);
      tgt = $urandom;
      step(rst, stl, br, tgt);
      n_cmp++;
      if (dut_vec() !== mdl_vec() || IF_pc[1:0] !== 2'b00) begin
        n_fail++;
        $display("FAIL random_%0d: got %h exp %h", i, dut_vec(), mdl_vec());
      end
    end
  endtask

  task automatic test_saturation();
    step(1'b1, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 65534; i++) step(1'b0, 1'b0, 1'b0, 32'h0);
    n_cmp++;
    if (fetch_count !== 16'hFFFE) begin
      n_fail++;
      $display("FAIL sat_pre: got %h exp fffe", fetch_count);
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 1'b0, 32'h0);
      n_cmp++;
      if (fetch_count !== 16'hFFFF || dut_vec() !== mdl_vec()) begin
        n_fail++;
        $display("FAIL sat_hold_%0d: got %h exp ffff", i, fetch_count);
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    Reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = 32'h0;
    for (int i = 0; i < 64; i++) rom[i] = $urandom;
    m_pc = 0; m_instr = 0; m_id_pc = 0; m_p4 = 0; m_valid = 0; m_cnt = 0;
    test_reset();
    test_sequential();
    test_stall();
    test_branch();
    test_branch_stall_reset();
    test_wrap();
    test_random();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
